// File: rtl/mm_result_collector.sv
// MXU result collector: de-skews per-lane results into a full-tile row buffer
// and writes completed rows, in order, to RAM over a valid/ready port.
module mm_result_collector #(
  parameter int LANES = 16,
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mm_res_cfg_vld,
  input  logic [3:0]            mm_res_cfg_row_len,
  input  logic [3:0]            mm_res_cfg_col_len,
  input  logic [AW+3:0]         mm_res_cfg_dst_addr,
  input  logic [LANES-1:0]      mxu_res_vld,
  input  logic [LANES*DW-1:0]   mxu_res_data,
  output logic                  mm_res_ram_wr_vld,
  output logic [AW-1:0]         mm_res_ram_wr_addr,
  output logic [LANES*DW-1:0]   mm_res_ram_wr_data,
  input  logic                  mm_res_ram_wr_rdy,
  output logic                  mm_res_busy,
  output logic                  mm_res_done,
  output logic                  mm_res_err
);

  localparam int RW = $clog2(DEPTH);
  localparam int LW = $clog2(LANES);
  localparam int PW = RW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [RW-1:0]        row_len_q, row_len_d;
  logic [LW-1:0]        col_len_q, col_len_d;
  logic [AW-1:0]        dst_row_q, dst_row_d;
  logic                 err_q, err_d;
  logic [PW-1:0]        ptr_q [LANES];
  logic [PW-1:0]        ptr_d [LANES];
  logic [PW-1:0]        wr_row_q, wr_row_d;
  logic                 wr_last_q, wr_last_d;
  logic                 wr_vld_q, wr_vld_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic [LANES*DW-1:0]  wr_data_q, wr_data_d;

  logic [LANES*DW-1:0]  rowbuf_q [DEPTH];
  logic [LANES-1:0]     cap;
  logic                 row_cplt;
  logic [LANES*DW-1:0]  rd_row;
  logic [LANES*DW-1:0]  masked_row;
  logic                 xfer;
  logic                 load;

  logic unused_addr_bits;
  assign unused_addr_bits = ^mm_res_cfg_dst_addr[3:0];

  // Row wr_row is complete once every active lane's pointer has moved past it.
  always_comb begin
    row_cplt = 1'b1;
    for (int j = 0; j < LANES; j++) begin
      if ((LW'(j) <= col_len_q) && (ptr_q[j] <= wr_row_q)) row_cplt = 1'b0;
    end
  end

  assign rd_row = rowbuf_q[wr_row_q[RW-1:0]];

  always_comb begin
    masked_row = '0;
    for (int j = 0; j < LANES; j++) begin
      if (LW'(j) <= col_len_q) masked_row[j*DW +: DW] = rd_row[j*DW +: DW];
    end
  end

  assign xfer = wr_vld_q & mm_res_ram_wr_rdy;
  assign load = (state_q == S_COLLECT) && (!wr_vld_q || mm_res_ram_wr_rdy) &&
                (wr_row_q <= {1'b0, row_len_q}) && row_cplt;

  always_comb begin
    state_d   = state_q;
    row_len_d = row_len_q;
    col_len_d = col_len_q;
    dst_row_d = dst_row_q;
    err_d     = err_q;
    wr_row_d  = wr_row_q;
    wr_last_d = wr_last_q;
    wr_vld_d  = wr_vld_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cap       = '0;
    for (int j = 0; j < LANES; j++) ptr_d[j] = ptr_q[j];

    case (state_q)
      S_IDLE: begin
        if (mm_res_cfg_vld) begin
          state_d   = S_COLLECT;
          row_len_d = mm_res_cfg_row_len[RW-1:0];
          col_len_d = mm_res_cfg_col_len[LW-1:0];
          dst_row_d = mm_res_cfg_dst_addr[AW+3:4];
          err_d     = 1'b0;
          wr_row_d  = '0;
          wr_last_d = 1'b0;
          for (int j = 0; j < LANES; j++) ptr_d[j] = '0;
        end
      end
      S_COLLECT: begin
        // Lanes capture independently; out-of-range bytes are dropped and flagged.
        for (int j = 0; j < LANES; j++) begin
          if (mxu_res_vld[j]) begin
            if ((LW'(j) <= col_len_q) && (ptr_q[j] <= {1'b0, row_len_q})) begin
              cap[j]   = 1'b1;
              ptr_d[j] = ptr_q[j] + PW'(1);
            end else begin
              err_d = 1'b1;
            end
          end
        end
        if (xfer) begin
          wr_vld_d = 1'b0;
          if (wr_last_q) state_d = S_DONE;
        end
        if (load) begin
          wr_vld_d  = 1'b1;
          wr_addr_d = dst_row_q + AW'(wr_row_q);
          wr_data_d = masked_row;
          wr_row_d  = wr_row_q + PW'(1);
          wr_last_d = (wr_row_q == {1'b0, row_len_q});
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      row_len_q <= '0;
      col_len_q <= '0;
      dst_row_q <= '0;
      err_q     <= 1'b0;
      wr_row_q  <= '0;
      wr_last_q <= 1'b0;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int j = 0; j < LANES; j++) ptr_q[j] <= '0;
    end else begin
      state_q   <= state_d;
      row_len_q <= row_len_d;
      col_len_q <= col_len_d;
      dst_row_q <= dst_row_d;
      err_q     <= err_d;
      wr_row_q  <= wr_row_d;
      wr_last_q <= wr_last_d;
      wr_vld_q  <= wr_vld_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      for (int j = 0; j < LANES; j++) ptr_q[j] <= ptr_d[j];
    end
  end

  // Row buffer holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int j = 0; j < LANES; j++) begin
      if (cap[j]) rowbuf_q[ptr_q[j][RW-1:0]][j*DW +: DW] <= mxu_res_data[j*DW +: DW];
    end
  end

  assign mm_res_ram_wr_vld  = wr_vld_q;
  assign mm_res_ram_wr_addr = wr_addr_q;
  assign mm_res_ram_wr_data = wr_data_q;
  assign mm_res_busy        = (state_q != S_IDLE);
  assign mm_res_done        = (state_q == S_DONE);
  assign mm_res_err         = err_q;

endmodule
